// File: rtl/out_port_fifo.sv
// out_port_fifo
//   Captures CPU OUT-port writes into a small first-word-fall-through FIFO.
//   An external sink drains it over a valid/ready handshake. A write that
//   arrives while the FIFO is full is dropped, and a sticky overflow flag
//   records the loss.
//
//   Optional build macro: OUT_FIFO_DEDUP_EN
//     When defined, a write whose data equals the last accepted write is
//     silently discarded. This suppresses repeated OUT of an unchanged value.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   wr_en     in   CPU OUT strobe, one write per cycle it is high
//   wr_data   in   [DATA_W]   value on the CPU out_port
//   rd_valid  out  head entry available (!empty)
//   rd_data   out  [DATA_W]   head entry, no read latency
//   rd_ready  in   sink accepts the head this cycle
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  [ADDR_W+1] occupancy, 0..DEPTH
//   overflow  out  sticky: a write was dropped because the FIFO was full
//   clr_ovf   in   clears overflow (a simultaneous new drop wins)
module out_port_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,   // power of 2, minimum 2
  parameter int ADDR_W = 3    // log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic push;
  logic pop;
  logic drop;
  logic dup;

  // Status flags come only from the registered count. This leaves no
  // combinational path from wr_en to any output.
  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr];

  // When the FIFO is full, a pop in the same cycle frees the slot for the
  // push. wr_ptr equals rd_ptr at that point, so the incoming word overwrites
  // the head that is leaving on this same edge.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && !dup && (!full || pop);
  assign drop = wr_en && !dup && full && !pop;

`ifdef OUT_FIFO_DEDUP_EN
  logic [DATA_W-1:0] last_data;
  logic              last_vld;

  assign dup = last_vld && (wr_data == last_data);

  // Only accepted pushes update the reference value. A write dropped on
  // full leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld  <= 1'b0;
      last_data <= '0;
    end else if (push) begin
      last_vld  <= 1'b1;
      last_data <= wr_data;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // NOTE: the storage array has no reset. Clearing the pointers and the count
  // is enough to discard its contents, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;  // natural wrap, DEPTH is 2**ADDR_W
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // A new drop takes priority over a clear in the same cycle.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo.
// The bench applies a table of {inputs, expected outputs} vectors, one per
// clock. It then runs hand-written sequences for the wrap-around,
// reset-mid-operation and (when built with OUT_FIFO_DEDUP_EN) dedup cases.
module tb_out_port_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_ovf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Each vector holds the inputs for one cycle. The expected fields are the
  // outputs observed just after the following rising edge.
  typedef struct {
    string             name;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_ready;
    logic              clr_ovf;
    logic [ADDR_W:0]   exp_count;
    logic              exp_ovf;
    logic              chk_data;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic w,
                              input logic [DATA_W-1:0] d, input logic rr,
                              input logic c, input logic [ADDR_W:0] ec,
                              input logic eo, input logic cd,
                              input logic [DATA_W-1:0] ed);
    vec_t v;
    v.name = n; v.rst = r; v.wr_en = w; v.wr_data = d; v.rd_ready = rr;
    v.clr_ovf = c; v.exp_count = ec; v.exp_ovf = eo; v.chk_data = cd;
    v.exp_data = ed;
    return v;
  endfunction

  // Inputs change 1 time unit after a rising edge, and outputs are sampled
  // at that same point, well away from the next active edge.
  task automatic run_vec(input vec_t v);
    rst      = v.rst;
    wr_en    = v.wr_en;
    wr_data  = v.wr_data;
    rd_ready = v.rd_ready;
    clr_ovf  = v.clr_ovf;
    @(posedge clk);
    #1;
    check({v.name, ".count"},    32'(count),    32'(v.exp_count));
    check({v.name, ".full"},     32'(full),     32'(v.exp_count == (ADDR_W+1)'(DEPTH)));
    check({v.name, ".empty"},    32'(empty),    32'(v.exp_count == '0));
    check({v.name, ".rd_valid"}, 32'(rd_valid), 32'(v.exp_count != '0));
    check({v.name, ".overflow"}, 32'(overflow), 32'(v.exp_ovf));
    if (v.chk_data) check({v.name, ".rd_data"}, 32'(rd_data), 32'(v.exp_data));
  endtask

  initial begin
    // ---------------- vector table ----------------
    //               name         rst wr  data      rdy clr cnt ovf chk exp_data
    vecs.push_back(mk("reset",     1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk("idle",      0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk("wr_a5a5",   0, 1, 16'hA5A5, 0, 0, 1, 0, 1, 16'hA5A5));
    vecs.push_back(mk("hold",      0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'hA5A5));
    vecs.push_back(mk("rd_a5a5",   0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk("rd_empty",  0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk($sformatf("fill%0d", i), 0, 1, DATA_W'(i), 0, 0,
                        (ADDR_W+1)'(i), 0, 1, 16'h0001));
    vecs.push_back(mk("wr_drop9",  0, 1, 16'h0009, 0, 0, 8, 1, 1, 16'h0001));
    // A clear and a new drop in the same cycle: the set wins.
    vecs.push_back(mk("clr_vs_set",0, 1, 16'h000A, 0, 1, 8, 1, 1, 16'h0001));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk($sformatf("drain%0d", k), 0, 0, 16'h0000, 1, 0,
                        (ADDR_W+1)'(8 - k), 1, (k < 8) ? 1'b1 : 1'b0,
                        DATA_W'(k + 1)));
    vecs.push_back(mk("clr_ovf",   0, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk($sformatf("refill%0d", i), 0, 1, DATA_W'(i), 0, 0,
                        (ADDR_W+1)'(i), 0, 1, 16'h0001));
    // Full, write plus pop in the same cycle: accepted, no overflow.
    vecs.push_back(mk("full_pushpop", 0, 1, 16'h00FF, 1, 0, 8, 0, 1, 16'h0002));
    for (int k = 1; k <= 6; k++)
      vecs.push_back(mk($sformatf("drain_b%0d", k), 0, 0, 16'h0000, 1, 0,
                        (ADDR_W+1)'(8 - k), 0, 1, DATA_W'(k + 2)));
    vecs.push_back(mk("drain_b7",  0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h00FF));
    vecs.push_back(mk("drain_b8",  0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));
    // Empty with write and ready: no bypass, the data stays queued.
    vecs.push_back(mk("no_bypass", 0, 1, 16'h1234, 1, 0, 1, 0, 1, 16'h1234));
    vecs.push_back(mk("rd_1234",   0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));

    foreach (vecs[i]) run_vec(vecs[i]);

    // ---------------- wrap-around: 3 preloaded, 20 push+pop ----------------
    for (int i = 0; i < 3; i++)
      run_vec(mk($sformatf("preload%0d", i), 0, 1, DATA_W'(16'h0100 + i), 0, 0,
                 (ADDR_W+1)'(i + 1), 0, 1, 16'h0100));
    // Cycle i pops 0x100+i and pushes 0x103+i, so the next head is 0x101+i.
    for (int i = 0; i < 20; i++)
      run_vec(mk($sformatf("wrap%0d", i), 0, 1, DATA_W'(16'h0103 + i), 1, 0,
                 3, 0, 1, DATA_W'(16'h0101 + i)));

    // ---------------- reset mid-operation ----------------
    // The reset overrides a concurrent write, and the next write becomes the head.
    run_vec(mk("mid_rst",    1, 1, 16'hDEAD, 1, 0, 0, 0, 0, 16'h0000));
    run_vec(mk("post_rst_w", 0, 1, 16'h7777, 0, 0, 1, 0, 1, 16'h7777));
    run_vec(mk("post_rst_r", 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));

`ifdef OUT_FIFO_DEDUP_EN
    // ---------------- dedup: 5,5,5,6,5 -> queue 5,6,5 ----------------
    run_vec(mk("dd_rst", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000));
    run_vec(mk("dd_w5a", 0, 1, 16'h0005, 0, 0, 1, 0, 1, 16'h0005));
    run_vec(mk("dd_w5b", 0, 1, 16'h0005, 0, 0, 1, 0, 1, 16'h0005));
    run_vec(mk("dd_w5c", 0, 1, 16'h0005, 0, 0, 1, 0, 1, 16'h0005));
    run_vec(mk("dd_w6",  0, 1, 16'h0006, 0, 0, 2, 0, 1, 16'h0005));
    run_vec(mk("dd_w5d", 0, 1, 16'h0005, 0, 0, 3, 0, 1, 16'h0005));
    run_vec(mk("dd_r1",  0, 0, 16'h0000, 1, 0, 2, 0, 1, 16'h0006));
    run_vec(mk("dd_r2",  0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h0005));
    run_vec(mk("dd_r3",  0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));
    // Reset clears last_vld, so the same value is accepted again.
    run_vec(mk("dd_rst2", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000));
    run_vec(mk("dd_w5e",  0, 1, 16'h0005, 0, 0, 1, 0, 1, 16'h0005));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
- Downstream consumer of the CPU's 16-bit `out_port`.
- Captures each CPU OUT write, qualified by a write strobe, into a small first-word-fall-through FIFO.
- Drains the FIFO to an external sink (display, UART, or testbench monitor) over a valid/ready handshake.
- Decouples CPU OUT bursts from a slower consumer and flags lost writes.

Parameters:
- DATA_W, 16, width of the OUT port data.
- DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointer width. Count width is ADDR_W+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  CPU OUT strobe; one write per cycle it is high.
- wr_data  in  DATA_W  value driven on `out_port` by the CPU.
- rd_valid  out  1  head entry available (equals !empty).
- rd_data  out  DATA_W  head entry; fall-through, no read latency.
- rd_ready  in  1  sink accepts head this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- clr_ovf  in  1  clears `overflow`.

Behaviour:
- Reset, checked first on every edge and overriding all other inputs:
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Outputs: empty = 1, full = 0, rd_valid = 0.
  - rd_data value is don't-care while empty.
  - Storage contents are not cleared.
- Reset mid-operation discards all queued entries; the first write after reset lands at entry 0.
- Push:
  - Occurs when wr_en && (!full || pop).
  - Writes wr_data to mem[wr_ptr]; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop:
  - Occurs when rd_valid && rd_ready; rd_ptr increments with the same wrap.
  - rd_ready while empty has no effect on pointers or count.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
- Latency: a write at edge N gives rd_valid = 1 and rd_data = that value from edge N onward, i.e. visible in cycle N+1.
- Full with wr_en and a pop in the same cycle: the write is accepted, count stays DEPTH, no overflow.
- Full with wr_en and no pop: the write is dropped, no state changes, overflow is set to 1.
- Empty with wr_en and rd_ready: no bypass. Only the push happens; the data appears next cycle.
- overflow stays high until clr_ovf or rst. If clr_ovf and a new drop occur in the same cycle, set wins.
- rd_data holds stable while rd_valid && !rd_ready, per the sink handshake rule.
- full, empty, rd_valid and count are all derived from the registered count; no combinational path from wr_en.

Optional Feature:
- Macro: OUT_FIFO_DEDUP_EN
- Enabled:
  - Adds a last_data register and a last_vld flag, both cleared by rst.
  - A write with last_vld && wr_data == last_data is silently discarded: no push, no overflow.
  - Every accepted push loads last_data = wr_data and sets last_vld.
  - A write dropped on full does not update last_data.
  - Purpose: suppress repeated OUT of an unchanged value, e.g. in polling loops.
- Disabled: every write is handled per the base rules. No extra registers.

Test Plan:
- Reset then idle: after rst high for 1 cycle, expect empty = 1, count = 0, rd_valid = 0, overflow = 0.
- Single write: wr_data = 16'hA5A5 with wr_en for 1 cycle, rd_ready = 0 -> next cycle rd_valid = 1, rd_data = 16'hA5A5, count = 1. Then rd_ready for 1 cycle -> empty = 1.
- Fill and overflow:
  - Write 16'h0001..16'h0008 on 8 consecutive cycles -> full = 1, count = 8.
  - Write 16'h0009 -> overflow = 1, count = 8.
  - Drain -> values 1..8 in order, 9 never appears.
  - clr_ovf -> overflow = 0.
- Simultaneous push/pop at full: with 8 entries queued, assert wr_en with 16'h00FF and rd_ready in the same cycle -> count stays 8, overflow stays 0, and 16'h00FF is read last after draining.
- Wrap-around: 20 cycles of simultaneous push and pop of incrementing data starting at 16'h0100, with 3 entries preloaded -> output sequence is continuous with no loss or duplication; count stays 3.
- With OUT_FIFO_DEDUP_EN: write 16'h0005 three times, then 16'h0006, then 16'h0005 -> count = 3 and read order is 5, 6, 5. Then reset and write 16'h0005 -> accepted, count = 1.
